// File: rtl/stable_sel_mux_pkg.sv
// Shared types and sizing helpers for the stable-select multiplexer.
package stable_sel_mux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  // Select width is max(1, clog2(nch)).
  function automatic int sel_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

  // Counter width wide enough to hold the value `stable` itself.
  function automatic int cnt_width(input int stable);
    return $clog2(stable + 1);
  endfunction

endpackage : stable_sel_mux_pkg

// File: rtl/sel_qualifier.sv
// Select-request qualifier: a channel change commits only after the same
// qualified request has been seen on STABLE consecutive rising edges.
module sel_qualifier
  import stable_sel_mux_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int STABLE = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [sel_width(NCH)-1:0] sel_req,
  input  logic                      sel_en1,
  input  logic                      sel_en2,
  output logic [sel_width(NCH)-1:0] sel_cur,
  output logic                      pending
);

  localparam int SELW = sel_width(NCH);
  localparam int CW   = cnt_width(STABLE);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_DONE = CW'(STABLE);

  state_e          state_q, state_d;
  logic [SELW-1:0] cand_q, cand_d;
  logic [SELW-1:0] sel_cur_q, sel_cur_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qualified;

  // Out-of-range requests are indistinguishable from no request.
  assign qualified = sel_en1 & sel_en2 & (int'(sel_req) < NCH);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    sel_cur_d = sel_cur_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (qualified && (sel_req != sel_cur_q)) begin
          cand_d = sel_req;
          if (STABLE == 1) begin
            sel_cur_d = sel_req;
            cnt_d     = '0;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = ARMED;
          end
        end
      end

      ARMED: begin
        if (qualified && (sel_req == cand_q)) begin
          if ((cnt_q + CNT_ONE) == CNT_DONE) begin
            sel_cur_d = cand_q;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (qualified && (sel_req != sel_cur_q)) begin
          // A different candidate restarts qualification from one.
          cand_d = sel_req;
          cnt_d  = CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      sel_cur_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      sel_cur_q <= sel_cur_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sel_cur = sel_cur_q;
  assign pending = (state_q == ARMED);

endmodule : sel_qualifier

// File: rtl/stable_sel_mux.sv
// Registered NCH:1 data selector whose select changes only after a
// qualified request has been stable for STABLE cycles.
module stable_sel_mux
  import stable_sel_mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCH    = 4,
  parameter int STABLE = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCH*WIDTH-1:0]      din,
  input  logic [sel_width(NCH)-1:0] sel_req,
  input  logic                      sel_en1,
  input  logic                      sel_en2,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [sel_width(NCH)-1:0] sel_cur,
  output logic                      pending
);

  localparam int SELW = sel_width(NCH);

  logic [SELW-1:0]  sel_cur_w;
  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] out_q, out_d;

  sel_qualifier #(
    .NCH    (NCH),
    .STABLE (STABLE)
  ) u_sel_qualifier (
    .clk     (clk),
    .reset   (reset),
    .sel_req (sel_req),
    .sel_en1 (sel_en1),
    .sel_en2 (sel_en2),
    .sel_cur (sel_cur_w),
    .pending (pending)
  );

  // The mux reads the registered select, so a commit reaches out one edge later.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(sel_cur_w) == k) begin
        mux_data = din[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (!hold) begin
      out_d = mux_data;
    end
  end

  // NOTE: reset takes priority over hold, so a held output still clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out     = out_q;
  assign sel_cur = sel_cur_w;

endmodule : stable_sel_mux

// File: tb/tb_stable_sel_mux.sv
// Directed bench for stable_sel_mux: a per-cycle vector table on the default
// configuration plus a short sequence on an NCH=3, STABLE=1 instance.
module tb_stable_sel_mux;

  logic        clk;
  logic        reset;
  logic [31:0] din;
  logic [1:0]  sel_req;
  logic        sel_en1, sel_en2, hold;
  logic [7:0]  out;
  logic [1:0]  sel_cur;
  logic        pending;

  logic        reset3;
  logic [23:0] din3;
  logic [1:0]  sel_req3;
  logic        sel_en13, sel_en23, hold3;
  logic [7:0]  out3;
  logic [1:0]  sel_cur3;
  logic        pending3;

  int n_cmp = 0;
  int n_err = 0;

  stable_sel_mux #(.WIDTH(8), .NCH(4), .STABLE(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .sel_req (sel_req),
    .sel_en1 (sel_en1),
    .sel_en2 (sel_en2),
    .hold    (hold),
    .out     (out),
    .sel_cur (sel_cur),
    .pending (pending)
  );

  stable_sel_mux #(.WIDTH(8), .NCH(3), .STABLE(1)) dut3 (
    .clk     (clk),
    .reset   (reset3),
    .din     (din3),
    .sel_req (sel_req3),
    .sel_en1 (sel_en13),
    .sel_en2 (sel_en23),
    .hold    (hold3),
    .out     (out3),
    .sel_cur (sel_cur3),
    .pending (pending3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       e1;
    logic       e2;
    logic       hld;
    logic [7:0] x_out;
    logic [1:0] x_sel;
    logic       x_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] req, input logic e1, input logic e2,
                     input logic hld, input logic [7:0] x_out, input logic [1:0] x_sel,
                     input logic x_pend);
    vec_t v;
    v.rst = rst; v.req = req; v.e1 = e1; v.e2 = e2; v.hld = hld;
    v.x_out = x_out; v.x_sel = x_sel; v.x_pend = x_pend;
    vecs.push_back(v);
  endtask

  // Drive one cycle on the NCH=3 instance and check after the edge.
  task automatic step3(input string name, input logic rst, input logic [1:0] req,
                       input logic en, input logic [7:0] x_out, input logic [1:0] x_sel);
    reset3 = rst; sel_req3 = req; sel_en13 = en; sel_en23 = en;
    @(posedge clk);
    #1;
    check({name, ".out"},     32'(out3),     32'(x_out));
    check({name, ".sel_cur"}, 32'(sel_cur3), 32'(x_sel));
    check({name, ".pending"}, 32'(pending3), 32'd0);
  endtask

  initial begin
    din   = {8'h44, 8'h33, 8'h22, 8'h11};
    din3  = {8'h33, 8'h22, 8'h11};
    reset = 1'b1; sel_req = '0; sel_en1 = 1'b0; sel_en2 = 1'b0; hold = 1'b0;
    reset3 = 1'b1; sel_req3 = '0; sel_en13 = 1'b0; sel_en23 = 1'b0; hold3 = 1'b0;

    //   rst req e1 e2 hld  out    sel pend
    // reset, then reset overriding a held qualified request
    add(1, 0, 0, 0, 0, 8'h00, 0, 0);
    add(1, 2, 1, 1, 1, 8'h00, 0, 0);
    add(0, 0, 0, 0, 0, 8'h11, 0, 0);
    // clean switch to channel 2
    add(0, 2, 1, 1, 0, 8'h11, 0, 1);
    add(0, 2, 1, 1, 0, 8'h11, 0, 1);
    add(0, 2, 1, 1, 0, 8'h11, 2, 0);
    add(0, 2, 1, 1, 0, 8'h33, 2, 0);
    // back to channel 0
    add(0, 0, 1, 1, 0, 8'h33, 2, 1);
    add(0, 0, 1, 1, 0, 8'h33, 2, 1);
    add(0, 0, 1, 1, 0, 8'h33, 0, 0);
    add(0, 0, 0, 0, 0, 8'h11, 0, 0);
    // glitch: 2 qualified, qualifier drop, 2 qualified, then release
    add(0, 3, 1, 1, 0, 8'h11, 0, 1);
    add(0, 3, 1, 1, 0, 8'h11, 0, 1);
    add(0, 3, 1, 0, 0, 8'h11, 0, 0);
    add(0, 3, 1, 1, 0, 8'h11, 0, 1);
    add(0, 3, 1, 1, 0, 8'h11, 0, 1);
    add(0, 3, 0, 1, 0, 8'h11, 0, 0);
    // re-arm: 1 for two edges, then 2 for three edges
    add(0, 1, 1, 1, 0, 8'h11, 0, 1);
    add(0, 1, 1, 1, 0, 8'h11, 0, 1);
    add(0, 2, 1, 1, 0, 8'h11, 0, 1);
    add(0, 2, 1, 1, 0, 8'h11, 0, 1);
    add(0, 2, 1, 1, 0, 8'h11, 2, 0);
    add(0, 0, 0, 0, 0, 8'h33, 2, 0);
    // request equal to sel_cur while armed drops back to idle
    add(0, 1, 1, 1, 0, 8'h33, 2, 1);
    add(0, 2, 1, 1, 0, 8'h33, 2, 0);
    // commit to channel 0 again
    add(0, 0, 1, 1, 0, 8'h33, 2, 1);
    add(0, 0, 1, 1, 0, 8'h33, 2, 1);
    add(0, 0, 1, 1, 0, 8'h33, 0, 0);
    add(0, 0, 0, 0, 0, 8'h11, 0, 0);
    // hold while committing to channel 2, then release hold
    add(0, 2, 1, 1, 1, 8'h11, 0, 1);
    add(0, 2, 1, 1, 1, 8'h11, 0, 1);
    add(0, 2, 1, 1, 1, 8'h11, 2, 0);
    add(0, 0, 0, 0, 1, 8'h11, 2, 0);
    add(0, 0, 0, 0, 0, 8'h33, 2, 0);
    // reset mid-qualification
    add(0, 1, 1, 1, 0, 8'h33, 2, 1);
    add(1, 1, 1, 1, 0, 8'h00, 0, 0);
    add(0, 1, 1, 1, 0, 8'h11, 0, 1);
    add(0, 0, 0, 0, 0, 8'h11, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      sel_req = vecs[i].req;
      sel_en1 = vecs[i].e1;
      sel_en2 = vecs[i].e2;
      hold    = vecs[i].hld;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.out", i),     32'(out),     32'(vecs[i].x_out));
      check($sformatf("v%0d.sel_cur", i), 32'(sel_cur), 32'(vecs[i].x_sel));
      check($sformatf("v%0d.pending", i), 32'(pending), 32'(vecs[i].x_pend));
    end

    // NCH=3, STABLE=1: out-of-range ignored, in-range commits on the same edge
    step3("n3_reset",  1'b1, 2'd0, 1'b0, 8'h00, 2'd0);
    step3("n3_oor_a",  1'b0, 2'd3, 1'b1, 8'h11, 2'd0);
    step3("n3_oor_b",  1'b0, 2'd3, 1'b1, 8'h11, 2'd0);
    step3("n3_commit", 1'b0, 2'd2, 1'b1, 8'h11, 2'd2);
    step3("n3_data",   1'b0, 2'd0, 1'b0, 8'h33, 2'd2);
    step3("n3_ch1",    1'b0, 2'd1, 1'b1, 8'h33, 2'd1);
    step3("n3_data1",  1'b0, 2'd1, 1'b0, 8'h22, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_stable_sel_mux

// File: doc/stable_sel_mux.md
# stable_sel_mux

Registered N-channel, WIDTH-bit data selector whose channel select is committed only after a qualified request has been held stable for a programmable number of cycles. It is the parametrised, sequential successor of the two-qualifier 2:1 selector, where data b is chosen only when both sel_b1 and sel_b2 are high. Here both qualifiers gate any channel change, and glitchy or short requests are filtered out. The block sits between multi-source data producers and a single downstream consumer that must never see select chatter.

## Interface
Parameters:
- WIDTH, 8, data width per channel (≥1)
- NCH, 4, number of input channels (≥2)
- STABLE, 3, consecutive qualifying sample edges required before a select commits (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- din  in  NCH*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH]
- sel_req  in  SELW  requested channel; SELW = max(1, $clog2(NCH))
- sel_en1  in  1  request qualifier 1
- sel_en2  in  1  request qualifier 2; a request is valid only when sel_en1 & sel_en2
- hold  in  1  freezes out at its current value
- out  out  WIDTH  registered selected data
- sel_cur  out  SELW  committed channel
- pending  out  1  high while a candidate is being qualified

## Operation
- A request is qualified when sel_en1 & sel_en2 = 1 and sel_req < NCH. Out-of-range sel_req is treated as no request.
- FSM states: IDLE and ARMED. pending = (state == ARMED).
- IDLE:
  - A qualified request with sel_req ≠ sel_cur latches cand = sel_req and cnt = 1.
  - If STABLE = 1, sel_cur <= sel_req at that same edge and the FSM stays in IDLE.
  - Otherwise the FSM moves to ARMED.
- ARMED:
  - A qualified request with sel_req == cand increments cnt. When cnt reaches STABLE, sel_cur <= cand, cnt clears, and the FSM returns to IDLE.
  - A qualified request with sel_req ≠ cand and ≠ sel_cur re-arms: cand = sel_req, cnt = 1, FSM stays in ARMED.
  - Any other condition (qualifier low, out of range, or sel_req == sel_cur) returns the FSM to IDLE and clears cnt.
- Datapath: every edge with hold = 0, out <= din[sel_cur] using the pre-edge sel_cur register value. With hold = 1, out keeps its value.
- hold does not affect select qualification or commits.
- Reset values: out = 0, sel_cur = 0, pending = 0, state = IDLE, cnt = 0, cand = 0.

## Timing
- A request first sampled at edge E0 and held continuously commits sel_cur at edge E0+STABLE−1. out first carries the new channel's data at edge E0+STABLE.
- out latency from din (same channel, hold = 0) is 1 cycle.
- Any break in qualification restarts the count from zero. A new request must again be held for the full STABLE edges.
- reset overrides all inputs in the same cycle. Reset mid-qualification discards cand, and out returns to 0.
- Reset asserted together with hold still clears out.
- cnt width is $clog2(STABLE+1). cnt never exceeds STABLE.

## Structure
- Shared package stable_sel_mux_pkg holds:
  - state enum {IDLE, ARMED}
  - function sel_width(NCH) returning max(1, $clog2(NCH))
- One sub-module, sel_qualifier, holds the FSM, cand and cnt, and outputs sel_cur and pending.
- The top level adds the WIDTH-bit NCH:1 mux and the out/hold register.

## Test plan
All scenarios use WIDTH=8, NCH=4, STABLE=3, din = {8'h44, 8'h33, 8'h22, 8'h11}.
- Reset:
  - Stimulus: assert reset 2 cycles.
  - Required: out = 8'h00, sel_cur = 0, pending = 0. One edge after release with no request, out = 8'h11.
- Clean switch:
  - Stimulus: sel_req = 2, sel_en1 = sel_en2 = 1 held from edge E0.
  - Required: pending = 1 after E0 and E1; sel_cur = 2 and pending = 0 after E0+2; out = 8'h33 after E0+3.
- Glitch filtering:
  - Stimulus: qualified sel_req = 3 for 2 edges, then sel_en2 = 0 for 1 edge, then qualified again for 2 edges.
  - Required: sel_cur stays 0 and out stays 8'h11 throughout.
- Re-arm and range checks:
  - Stimulus: qualified sel_req = 1 for 2 edges, then sel_req = 2 for 3 edges.
  - Required: sel_cur = 2 at the third edge of sel_req = 2; sel_cur never passes through 1.
  - Also exercised: with NCH = 3, a qualified sel_req = 3 is ignored (pending stays 0).
- Hold and reset mid-operation:
  - Stimulus: hold = 1 while committing to channel 2.
  - Required: out stays 8'h11 while sel_cur becomes 2. Releasing hold gives out = 8'h33 one edge later.
  - Stimulus: reset while pending = 1.
  - Required: pending = 0, sel_cur = 0, out = 8'h00.
